header_feeder: RTL and testbench

Nonce-sweeping header source and result checker sitting directly upstream of the double-SHA-256 core. Holds an 80-byte block header and a 256-bit target loaded by the host, serves header words to the core over its word-request bus, and substitutes a running nonce into word 19. For each candidate it launches one double hash, compares the result against the target, and either reports a winning nonce or advances to the next.

---
 rtl/feeder_pkg.sv | 23 ++
 rtl/target_cmp_serial.sv | 36 +++
 rtl/header_feeder.sv | 150 +++++++++++++++
 tb/tb_header_feeder.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/feeder_pkg.sv
// rtl/feeder_pkg.sv - shared state type, host load map and byte-swap helper for header_feeder
package feeder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        CMP,
        STEP,
        FOUND,
        EXHAUSTED
    } feeder_state_t;

    localparam int         HDR_WORDS      = 20;
    localparam logic [4:0] LD_NONCE_START = 5'd19;
    localparam logic [4:0] LD_TARGET0     = 5'd20;
    localparam logic [4:0] LD_NONCE_END   = 5'd28;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/target_cmp_serial.sv
// rtl/target_cmp_serial.sv - word-serial unsigned compare of a hash candidate against the target
module target_cmp_serial (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [255:0] hash_q,
    input  logic [255:0] target,
    output logic         done,
    output logic         hit
);
    import feeder_pkg::*;

    logic [2:0]  idx;
    logic [31:0] v_word;
    logic [31:0] t_word;

    // word index starts at the most significant word when a hash is captured, then walks down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (start) begin
            idx <= '0;
        end else if (idx != 3'd7) begin
            idx <= idx + 3'd1;
        end
    end

    // candidate word k is the byte-swapped k-th low word of the hash; target word 0 sits at the top
    always_comb begin
        v_word = bswap32(hash_q[{idx, 5'd0} +: 32]);
        t_word = target[{~idx, 5'd0} +: 32];
        done   = (v_word != t_word) || (idx == 3'd7);
        hit    = (v_word <= t_word);
    end

endmodule

// File: rtl/header_feeder.sv
// rtl/header_feeder.sv - nonce-sweeping header source and result checker for the double-SHA-256 core
module header_feeder #(
    parameter logic [31:0] NONCE_STEP = 32'd1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_valid,
    input  logic [4:0]   ld_addr,
    input  logic [31:0]  ld_data,
    input  logic         go,
    input  logic         stop,
    output logic         hash_start,
    input  logic         bus_rq,
    input  logic [4:0]   bus_addr,
    output logic [31:0]  bus_data,
    output logic         bus_rdy,
    input  logic [255:0] hash,
    input  logic         hash_done,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic [31:0]  nonce_out
);
    import feeder_pkg::*;

    feeder_state_t state;
    feeder_state_t state_nx;

    logic [31:0]  header [0:HDR_WORDS-2];
    logic [31:0]  target_w [0:7];
    logic [255:0] target;
    logic [31:0]  nonce_start;
    logic [31:0]  nonce_end;
    logic [31:0]  nonce;
    logic [255:0] hash_q;
    logic         stop_pend;
    logic         idle_like;
    logic         load_ok;
    logic         sweep_go;
    logic         capture;
    logic [2:0]   tgt_sel;
    logic         cmp_done;
    logic         cmp_hit;

    assign idle_like = (state == IDLE) || (state == FOUND) || (state == EXHAUSTED);
    assign load_ok   = ld_valid && idle_like;
    assign sweep_go  = go && idle_like;
    assign capture   = (state == WAIT) && hash_done;
    assign tgt_sel   = 3'(ld_addr - LD_TARGET0);
    assign target    = {target_w[0], target_w[1], target_w[2], target_w[3],
                        target_w[4], target_w[5], target_w[6], target_w[7]};

    assign busy       = (state == LAUNCH) || (state == WAIT) || (state == CMP) || (state == STEP);
    assign found      = (state == FOUND);
    assign exhausted  = (state == EXHAUSTED);
    assign hash_start = (state == LAUNCH);
    assign nonce_out  = nonce;
    assign bus_rdy    = bus_rq && (state == WAIT) && (bus_addr < 5'(HDR_WORDS));

    // host register file; writable whenever no sweep is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HDR_WORDS - 1; i++) header[i] <= '0;
            for (int i = 0; i < 8; i++) target_w[i] <= '0;
            nonce_start <= '0;
            nonce_end   <= '0;
        end else if (load_ok) begin
            if (ld_addr < LD_NONCE_START) begin
                header[ld_addr] <= ld_data;
            end else if (ld_addr == LD_NONCE_START) begin
                nonce_start <= ld_data;
            end else if (ld_addr < LD_NONCE_END) begin
                target_w[tgt_sel] <= ld_data;
            end else if (ld_addr == LD_NONCE_END) begin
                nonce_end <= ld_data;
            end
        end
    end

    // running nonce, captured hash and the sticky stop request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nonce     <= '0;
            hash_q    <= '0;
            stop_pend <= 1'b0;
        end else begin
            if (sweep_go) begin
                // a nonce_start write in the go cycle must be the value the sweep starts from
                nonce <= (load_ok && (ld_addr == LD_NONCE_START)) ? ld_data : nonce_start;
            end else if (state == STEP) begin
                nonce <= nonce + NONCE_STEP;
            end
            if (capture) begin
                hash_q <= hash;
            end
            stop_pend <= busy && (stop_pend || stop);
        end
    end

    // word 19 carries the nonce in header byte order
    always_comb begin
        bus_data = '0;
        if (bus_rdy) begin
            bus_data = (bus_addr == 5'(HDR_WORDS - 1)) ? bswap32(nonce) : header[bus_addr];
        end
    end

    target_cmp_serial u_cmp (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (capture),
        .hash_q (hash_q),
        .target (target),
        .done   (cmp_done),
        .hit    (cmp_hit)
    );

    // sweep state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // sweep sequencing: launch, wait for the core, compare, then step or finish
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, FOUND, EXHAUSTED: if (sweep_go) state_nx = LAUNCH;
            LAUNCH:                 state_nx = WAIT;
            WAIT:                   if (hash_done) state_nx = CMP;
            CMP: begin
                if (cmp_done) begin
                    if (cmp_hit) begin
                        state_nx = FOUND;
                    end else if ((nonce == nonce_end) || stop_pend || stop) begin
                        state_nx = EXHAUSTED;
                    end else begin
                        state_nx = STEP;
                    end
                end
            end
            STEP:                   state_nx = LAUNCH;
            default:                state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_header_feeder.sv
// tb/tb_header_feeder.sv - randomized self-checking bench for header_feeder with a core model
module tb_header_feeder;

    localparam logic [255:0] GEN_HASH =
        256'h6fe28c0ab6f1b372c1a6a246ae63f74f931e8365e15a089c68d6190000000000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         ld_valid = 1'b0;
    logic [4:0]   ld_addr = '0;
    logic [31:0]  ld_data = '0;
    logic         go = 1'b0;
    logic         stop = 1'b0;
    logic         hash_start;
    logic         bus_rq = 1'b0;
    logic [4:0]   bus_addr = '0;
    logic [31:0]  bus_data;
    logic         bus_rdy;
    logic [255:0] hash = '0;
    logic         hash_done = 1'b0;
    logic         busy;
    logic         found;
    logic         exhausted;
    logic [31:0]  nonce_out;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0]  nonce;
        logic [255:0] h;
        int           k;
        int           fin;
    } att_t;

    att_t         plan[$];
    att_t         cur;
    logic [31:0]  hdr_m [0:18];
    logic [255:0] tgt_m = '0;
    int           hmode = 0;
    int           launches = 0;
    int           cyc = 0;
    bit           inject_done = 1'b0;
    bit           stop_on_first = 1'b0;
    logic [31:0]  w19_seen = '0;
    int           exp_fin;
    logic [31:0]  exp_n;
    int           exp_launch;

    always #5 clk = ~clk;

    header_feeder #(.NONCE_STEP(32'd1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .go        (go),
        .stop      (stop),
        .hash_start(hash_start),
        .bus_rq    (bus_rq),
        .bus_addr  (bus_addr),
        .bus_data  (bus_data),
        .bus_rdy   (bus_rdy),
        .hash      (hash),
        .hash_done (hash_done),
        .busy      (busy),
        .found     (found),
        .exhausted (exhausted),
        .nonce_out (nonce_out)
    );

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bsw(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[b*8 +: 8] = w[(3-b)*8 +: 8];
        return r;
    endfunction

    // Bitcoin numeric value of a hash: the 32 bytes read in reverse order
    function automatic logic [255:0] v_of(input logic [255:0] h);
        logic [255:0] v;
        for (int b = 0; b < 32; b++) v[b*8 +: 8] = h[(31-b)*8 +: 8];
        return v;
    endfunction

    function automatic int k_of(input logic [255:0] v, input logic [255:0] t);
        for (int i = 0; i < 8; i++)
            if (v[255-32*i -: 32] != t[255-32*i -: 32]) return i + 1;
        return 8;
    endfunction

    function automatic logic [255:0] make_hash(input logic [31:0] n);
        logic [255:0] v;
        int           j;
        if (hmode == 0) return {8{n | 32'h1}};
        if (hmode == 1) return (n == 32'h7C2BAC1D) ? GEN_HASH : '1;
        j = $urandom_range(0, 8);
        v = tgt_m;
        for (int i = 0; i < 8; i++)
            if (i >= j) v[255-32*i -: 32] = $urandom;
        return v_of(v);
    endfunction

    task automatic build_plan(input logic [31:0] ns, input logic [31:0] ne, input bit stop1);
        logic [31:0]  n;
        logic [255:0] v;
        att_t         a;
        n = ns;
        plan.delete();
        for (int i = 0; i < 40; i++) begin
            a.nonce = n;
            a.h     = make_hash(n);
            v       = v_of(a.h);
            a.k     = k_of(v, tgt_m);
            if (v <= tgt_m) a.fin = 1;
            else if (n == ne || (stop1 && i == 0)) a.fin = 2;
            else a.fin = 0;
            plan.push_back(a);
            if (a.fin != 0) break;
            n = n + 32'd1;
        end
        exp_fin    = plan[plan.size()-1].fin;
        exp_n      = plan[plan.size()-1].nonce;
        exp_launch = plan.size();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        @(negedge clk);
        ld_valid = 1'b0;
    endtask

    task automatic load_target(input logic [255:0] t);
        for (int i = 0; i < 8; i++) wr(5'(20 + i), t[255-32*i -: 32]);
        tgt_m = t;
    endtask

    task automatic load_hdr(input int idx, input logic [31:0] d);
        wr(5'(idx), d);
        hdr_m[idx] = d;
    endtask

    task automatic sweep(input string tag, input logic [31:0] ns, input logic [31:0] ne,
                         input bit stop1, input bit sc);
        int budget;
        wr(5'd19, sc ? ~ns : ns);
        wr(5'd28, ne);
        build_plan(ns, ne, stop1);
        launches      = 0;
        stop_on_first = stop1;
        @(negedge clk);
        go = 1'b1;
        if (sc) begin
            ld_valid = 1'b1;
            ld_addr  = 5'd19;
            ld_data  = ns;
        end
        @(negedge clk);
        go       = 1'b0;
        ld_valid = 1'b0;
        budget   = 0;
        while (!(found || exhausted) && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        chk({tag, " finished"}, 256'(budget < 5000), 256'(1));
        chk({tag, " found"}, 256'(found), 256'(exp_fin == 1));
        chk({tag, " exhausted"}, 256'(exhausted), 256'(exp_fin == 2));
        chk({tag, " nonce_out"}, 256'(nonce_out), 256'(exp_n));
        chk({tag, " launches"}, 256'(launches), 256'(exp_launch));
        chk({tag, " plan drained"}, 256'(plan.size()), 256'(0));
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst busy", 256'(busy), 256'(0));
        chk("rst found", 256'(found), 256'(0));
        chk("rst exhausted", 256'(exhausted), 256'(0));
        chk("rst hash_start", 256'(hash_start), 256'(0));
        chk("rst bus_rdy", 256'(bus_rdy), 256'(0));
        chk("rst bus_data", 256'(bus_data), 256'(0));
        chk("rst nonce_out", 256'(nonce_out), 256'(0));
        @(posedge clk);
        #1 rst_n = 1'b1;
        plan.delete();
        for (int i = 0; i < 19; i++) hdr_m[i] = '0;
        tgt_m = '0;
    endtask

    // core model and per-cycle compare against the expected attempt sequence
    initial begin : core_model
        int   phase;
        int   wait_left;
        int   cnt;
        int   due;
        bit   first_wait;
        logic exp_rdy;
        phase = 0; wait_left = 0; cnt = 0; due = -1; first_wait = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                phase = 0; hash_done = 1'b0; bus_rq = 1'b0; stop = 1'b0; due = -1;
                continue;
            end
            exp_rdy = bus_rq && (phase == 1) && (bus_addr <= 5'd19);
            chk("bus_rdy", 256'(bus_rdy), 256'(exp_rdy));
            chk("bus_data", 256'(bus_data),
                256'(exp_rdy ? ((bus_addr == 5'd19) ? bsw(cur.nonce) : hdr_m[bus_addr]) : 32'h0));
            if (bus_rdy && bus_addr == 5'd19) w19_seen = bus_data;
            hash_done = 1'b0;
            stop      = 1'b0;
            bus_rq    = 1'($urandom_range(0, 1));
            bus_addr  = 5'($urandom_range(0, 23));
            if (phase == 0) begin
                if (hash_start) begin
                    launches++;
                    if (due >= 0) chk("launch cycle", 256'(cyc), 256'(due));
                    due = -1;
                    if (plan.size() == 0) begin
                        chk("unexpected launch", 256'(1), 256'(0));
                    end else begin
                        cur        = plan.pop_front();
                        phase      = 1;
                        wait_left  = $urandom_range(1, 8);
                        first_wait = 1'b1;
                        bus_rq     = 1'b1;
                        bus_addr   = 5'd19;
                    end
                end else if (due >= 0 && cyc >= due) begin
                    chk("launch missing", 256'(0), 256'(1));
                    due = -1;
                end
                if (inject_done) begin
                    hash_done   = 1'b1;
                    hash        = '1;
                    inject_done = 1'b0;
                end
            end else if (phase == 1) begin
                chk("wait busy", 256'(busy), 256'(1));
                chk("wait hash_start", 256'(hash_start), 256'(0));
                chk("wait nonce_out", 256'(nonce_out), 256'(cur.nonce));
                if (first_wait && stop_on_first && launches == 1) stop = 1'b1;
                first_wait = 1'b0;
                if (wait_left == 0) begin
                    hash_done = 1'b1;
                    hash      = cur.h;
                    phase     = 2;
                    cnt       = 0;
                end else begin
                    wait_left--;
                end
            end else begin
                cnt++;
                if (cnt <= cur.k) begin
                    chk("cmp busy", 256'(busy), 256'(1));
                end else begin
                    if (cur.fin == 0) begin
                        chk("step busy", 256'(busy), 256'(1));
                        due = cyc + 1;
                    end else begin
                        chk("end found", 256'(found), 256'(cur.fin == 1));
                        chk("end exhausted", 256'(exhausted), 256'(cur.fin == 2));
                        chk("end busy", 256'(busy), 256'(0));
                    end
                    phase = 0;
                end
            end
        end
    end

    initial begin : main
        logic [31:0] gen_hdr [0:18];
        logic [31:0] ns;
        int          budget;
        gen_hdr = '{32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                    32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3,
                    32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d};
        do_reset();

        hmode = 2;
        load_target('1);
        sweep("max target", 32'd5, 32'd5, 1'b0, 1'b0);
        chk("max target found lit", 256'(found), 256'(1));
        chk("max target nonce lit", 256'(nonce_out), 256'(32'd5));
        chk("max target launches lit", 256'(launches), 256'(1));

        hmode = 0;
        load_target('0);
        sweep("zero target", 32'd0, 32'd3, 1'b0, 1'b0);
        chk("zero target exhausted lit", 256'(exhausted), 256'(1));
        chk("zero target launches lit", 256'(launches), 256'(4));
        chk("zero target nonce lit", 256'(nonce_out), 256'(32'd3));

        hmode = 1;
        for (int i = 0; i < 19; i++) load_hdr(i, gen_hdr[i]);
        load_target({32'h0, 32'hFFFF0000, 192'h0});
        w19_seen = '0;
        sweep("genesis", 32'h7C2BAC1B, 32'h7C2BAC1F, 1'b0, 1'b0);
        chk("genesis found lit", 256'(found), 256'(1));
        chk("genesis nonce lit", 256'(nonce_out), 256'(32'h7C2BAC1D));
        chk("genesis launches lit", 256'(launches), 256'(3));
        chk("genesis word19 lit", 256'(w19_seen), 256'(32'h1DAC2B7C));

        hmode = 0;
        load_target('0);
        sweep("wrap", 32'hFFFFFFFF, 32'd1, 1'b0, 1'b0);
        chk("wrap exhausted lit", 256'(exhausted), 256'(1));
        chk("wrap launches lit", 256'(launches), 256'(3));
        chk("wrap nonce lit", 256'(nonce_out), 256'(32'd1));

        sweep("wrap stop", 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0);
        chk("wrap stop exhausted lit", 256'(exhausted), 256'(1));
        chk("wrap stop launches lit", 256'(launches), 256'(1));
        chk("wrap stop nonce lit", 256'(nonce_out), 256'(32'hFFFFFFFF));

        hmode = 2;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 3; i++) load_hdr($urandom_range(0, 18), $urandom);
            wr(5'($urandom_range(29, 31)), $urandom);
            load_target({32'h0, 32'($urandom), 32'($urandom), 32'($urandom),
                         32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)});
            ns = $urandom;
            sweep("random", ns, ns + 32'($urandom_range(0, 6)), 1'b0, 1'(r % 2));
        end

        hmode = 0;
        load_target('0);
        wr(5'd19, 32'd7);
        wr(5'd28, 32'd7);
        build_plan(32'd7, 32'd7, 1'b0);
        launches      = 0;
        stop_on_first = 1'b0;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        budget = 0;
        while (launches == 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("mid-wait launch seen", 256'(launches), 256'(1));
        do_reset();
        inject_done = 1'b1;
        repeat (6) @(negedge clk);
        chk("post-reset busy", 256'(busy), 256'(0));
        chk("post-reset found", 256'(found), 256'(0));
        chk("post-reset exhausted", 256'(exhausted), 256'(0));
        chk("post-reset launches", 256'(launches), 256'(1));
        chk("post-reset nonce_out", 256'(nonce_out), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
